// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexed digit scanner feeding a seven-segment
// decoder. Holds a double-buffered hex value that commits only at frame
// boundaries, walks the digits at a programmable rate with a guard interval
// at the start of each slot, and applies optional leading-zero blanking.
module hex_digit_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 16,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic                  load_ack,
    output logic [3:0]            val_out,
    output logic                  blank,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  dp_out
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);

    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] GUARD_LIM = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]              pcnt;
    logic [IW-1:0]              idx;
    logic [DIGITS-1:0][3:0]     disp_val;
    logic [DIGITS-1:0]          disp_dp;
    logic [DIGITS-1:0][3:0]     pend_val;
    logic [DIGITS-1:0]          pend_dp;
    logic                       pend_valid;

    logic                       tick;
    logic                       commit;
    logic [PW-1:0]              pcnt_nxt;
    logic [IW-1:0]              idx_nxt;
    logic [DIGITS-1:0][3:0]     disp_val_nxt;
    logic [DIGITS-1:0]          disp_dp_nxt;

    logic [DIGITS-1:0]          lz_mask;
    logic                       all_zero;
    int unsigned                dig;

    logic                       guard_nxt;
    logic [3:0]                 nib_nxt;
    logic                       dpb_nxt;
    logic                       lzb_nxt;
    logic [DIGITS-1:0]          sel_nxt;
    logic                       blank_nxt;
    logic                       dp_out_nxt;

    // Prescaler, digit index and frame-boundary commit decisions.
    always_comb begin
        tick         = (pcnt == PCNT_LAST);
        commit       = tick && (idx == IDX_LAST) && pend_valid;
        pcnt_nxt     = tick ? '0 : pcnt + 1'b1;
        idx_nxt      = idx;
        if (tick) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        disp_val_nxt = commit ? pend_val : disp_val;
        disp_dp_nxt  = commit ? pend_dp  : disp_dp;
    end

    // Leading-zero mask: digit i>0 blanks when it and every higher nibble are zero.
    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        dig      = 0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            dig      = DIGITS - 1 - j;
            all_zero = all_zero & (disp_val_nxt[dig] == 4'h0);
            if ((BLANK_LZ != 0) && (dig != 0)) begin
                lz_mask[dig] = all_zero;
            end
        end
    end

    // Output values for the post-edge slot position, registered below so
    // the outputs line up with the state they describe without extra latency.
    always_comb begin
        guard_nxt = (pcnt_nxt < GUARD_LIM);
        nib_nxt   = 4'h0;
        dpb_nxt   = 1'b0;
        lzb_nxt   = 1'b0;
        sel_nxt   = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib_nxt = disp_val_nxt[i];
                dpb_nxt = disp_dp_nxt[i];
                lzb_nxt = lz_mask[i];
                if (!guard_nxt) begin
                    sel_nxt[i] = 1'b0;
                end
            end
        end
        blank_nxt  = guard_nxt | lzb_nxt;
        dp_out_nxt = (guard_nxt | lzb_nxt) ? 1'b1 : ~dpb_nxt;
    end

    // Scan position and display buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt     <= '0;
            idx      <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            pcnt     <= pcnt_nxt;
            idx      <= idx_nxt;
            disp_val <= disp_val_nxt;
            disp_dp  <= disp_dp_nxt;
        end
    end

    // Pending buffer: a load always wins over a same-edge commit clearing the flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_ack  <= 1'b0;
            val_out   <= 4'h0;
            blank     <= 1'b1;
            digit_sel <= '1;
            dp_out    <= 1'b1;
        end else begin
            load_ack  <= commit;
            val_out   <= nib_nxt;
            blank     <= blank_nxt;
            digit_sel <= sel_nxt;
            dp_out    <= dp_out_nxt;
        end
    end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Scoreboard bench for hex_digit_scanner (DIGITS=4, PRESCALE=8, GUARD=2).
// Stimulus pushes expected per-slot displays and load_ack times; a monitor
// pops and compares them as the DUT presents each slot or ack.
module tb_hex_digit_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;

    logic        load_ack;
    logic [3:0]  val_out;
    logic        blank;
    logic [3:0]  digit_sel;
    logic        dp_out;

    logic        n_load_ack;
    logic [3:0]  n_val_out;
    logic        n_blank;
    logic [3:0]  n_digit_sel;
    logic        n_dp_out;

    hex_digit_scanner #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .BLANK_LZ(1)) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
        .load(load), .load_ack(load_ack), .val_out(val_out), .blank(blank),
        .digit_sel(digit_sel), .dp_out(dp_out)
    );

    hex_digit_scanner #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .BLANK_LZ(0)) dut_nolz (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
        .load(load), .load_ack(n_load_ack), .val_out(n_val_out), .blank(n_blank),
        .digit_sel(n_digit_sel), .dp_out(n_dp_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] sel;
        logic [3:0] val;
        logic       blk;
        logic       dp;
    } slot_t;

    slot_t exp_q[$];
    int    ack_q[$];
    int    checks = 0;
    int    failures = 0;
    int    ack_seen = 0;
    int    cyc = 0;

    // Cycles since the last reset edge; after edge c the slot position is c mod 8.
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push_frame(input int k, input logic [15:0] v,
                                       input logic [3:0] dp, input logic [3:0] mask,
                                       input int nslots);
        slot_t r;
        for (int s = 0; s < nslots; s++) begin
            r.t   = 32 * k + 8 * s + 2;
            r.sel = 4'b1111 & ~(4'b0001 << s);
            r.val = v[4*s +: 4];
            r.blk = mask[s];
            r.dp  = mask[s] ? 1'b1 : ~dp[s];
            exp_q.push_back(r);
        end
    endfunction

    // Monitor state
    int         gcnt = 0;
    int         act_len = 0;
    bit         in_act = 0;
    bit         tracked = 0;
    bit         unstable = 0;
    logic [3:0] s_val;
    logic       s_blk;
    logic       s_dp;
    logic [3:0] s_sel;

    always @(posedge clk) begin
        slot_t r;
        #1;
        if (!reset_n) begin
            gcnt   = 1;
            in_act = 0;
        end else begin
            while (ack_q.size() > 0 && ack_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL ack_missing: got none expected ack at cyc %0d", ack_q.pop_front());
            end
            if (load_ack) begin
                ack_seen++;
                if (ack_q.size() > 0) chk("ack_time", cyc, ack_q.pop_front());
                else chk("ack_unexpected", 1, 0);
            end
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                r = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL slot_missing: got no slot start expected sel %b at cyc %0d", r.sel, r.t);
            end
            if (digit_sel == 4'b1111) begin
                if (in_act) begin
                    if (tracked) begin
                        chk("active_len", act_len, 6);
                        chk("active_stable", int'(unstable), 0);
                    end
                    in_act = 0;
                    gcnt   = 0;
                end
                gcnt++;
                chk("guard_blank_dp", {blank, dp_out}, 2'b11);
            end else begin
                if (!in_act) begin
                    tracked = 0;
                    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
                        r = exp_q.pop_front();
                        tracked = 1;
                        chk("guard_len", gcnt, 2);
                        chk("slot_sel", digit_sel, r.sel);
                        chk("slot_blank", blank, r.blk);
                        chk("slot_dp", dp_out, r.dp);
                        if (!r.blk) chk("slot_val", val_out, r.val);
                    end
                    in_act   = 1;
                    act_len  = 0;
                    unstable = 0;
                    s_val = val_out; s_blk = blank; s_dp = dp_out; s_sel = digit_sel;
                end
                act_len++;
                if (val_out !== s_val || blank !== s_blk || dp_out !== s_dp || digit_sel !== s_sel)
                    unstable = 1;
            end
        end
    end

    // Park at the negedge just before the edge that makes cyc == c.
    task automatic goto(input int c);
        int n = 0;
        @(negedge clk);
        while (cyc != c - 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("goto_timeout", cyc, c - 1);
    endtask

    task automatic do_load(input int c, input logic [15:0] v, input logic [3:0] d);
        goto(c);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic sample_at(input int c);
        goto(c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"}, digit_sel, 4'b1111);
        chk({tag, "_blank"}, blank, 1);
        chk({tag, "_dp"}, dp_out, 1);
        chk({tag, "_val"}, val_out, 0);
        chk({tag, "_ack"}, load_ack, 0);
    endtask

    initial begin
        logic [15:0] lzv;
        logic [3:0]  lzsel;
        lzv = 16'h0030;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        push_frame(0, 16'h0000, 4'b0000, 4'b1110, 4);
        push_frame(1, 16'h0000, 4'b0000, 4'b1110, 4);
        reset_n = 1'b1;

        // Basic scan
        do_load(40, 16'h12AF, 4'b0100);
        ack_q.push_back(64);
        push_frame(2, 16'h12AF, 4'b0100, 4'b0000, 4);
        push_frame(3, 16'h12AF, 4'b0100, 4'b0000, 4);

        // Leading-zero blanking
        do_load(100, 16'h0030, 4'b0000);
        ack_q.push_back(128);
        push_frame(4, 16'h0030, 4'b0000, 4'b1100, 4);
        push_frame(5, 16'h0030, 4'b0000, 4'b1100, 4);
        for (int s = 0; s < 4; s++) begin
            sample_at(128 + 8 * s + 3);
            lzsel = 4'b1111 & ~(4'b0001 << s);
            chk("nolz_sel", n_digit_sel, lzsel);
            chk("nolz_blank", n_blank, 0);
            chk("nolz_val", n_val_out, lzv[4*s +: 4]);
        end

        // No tearing, last load wins
        do_load(170, 16'h1111, 4'b0000);
        ack_q.push_back(192);
        push_frame(6, 16'h1111, 4'b0000, 4'b0000, 4);
        do_load(203, 16'h2222, 4'b0000);
        do_load(211, 16'h3333, 4'b0000);
        ack_q.push_back(224);
        push_frame(7, 16'h3333, 4'b0000, 4'b0000, 4);

        // Load on the same edge as a commit
        do_load(240, 16'hAAAA, 4'b0000);
        ack_q.push_back(256);
        push_frame(8, 16'hAAAA, 4'b0000, 4'b0000, 4);
        do_load(256, 16'h5555, 4'b0000);
        ack_q.push_back(288);
        push_frame(9, 16'h5555, 4'b0000, 4'b0000, 2);

        // Reset mid-operation discards a pending load
        do_load(300, 16'hBEEF, 4'b0000);
        goto(308);
        chk("pre_reset_slot_q", exp_q.size(), 0);
        chk("pre_reset_ack_q", ack_q.size(), 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        push_frame(0, 16'h0000, 4'b0000, 4'b1110, 4);
        push_frame(1, 16'h0000, 4'b0000, 4'b1110, 4);
        push_frame(2, 16'h0000, 4'b0000, 4'b1110, 4);
        reset_n = 1'b1;

        sample_at(100);
        chk("slot_q_empty", exp_q.size(), 0);
        chk("ack_q_empty", ack_q.size(), 0);
        chk("ack_count", ack_seen, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hex_digit_scanner.md
# hex_digit_scanner

Time-multiplexed display scanner that sits directly upstream of the seven-segment decoder. It holds a multi-digit hex value in a tear-free double buffer, walks the digits at a programmable refresh rate, and presents one nibble per slot on `val_out` for the decoder, plus a one-hot active-low digit select, decimal point and blank flag. Leading-zero blanking and an inter-digit guard interval are applied here, so the decoder stays purely combinational.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `PRESCALE`, 50000: clock cycles per digit slot; must be at least `GUARD`+2.
- `GUARD`, 16: cycles at the start of each slot with every digit disabled (anti-ghosting).
- `BLANK_LZ`, 1: 1 enables leading-zero blanking; 0 shows every digit.

- `clk`, in, 1: system clock; all logic on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `value_in`, in, 4*DIGITS: value to display; nibble i drives digit i, and digit 0 is least significant.
- `dp_in`, in, DIGITS: decimal point request per digit, active-high.
- `load`, in, 1: single-cycle strobe that captures `value_in` and `dp_in` into the pending buffer.
- `load_ack`, out, 1: one-cycle pulse when the pending buffer is committed to the display buffer.
- `val_out`, out, 4: nibble for the current digit; connects to the decoder's `val_in`.
- `blank`, out, 1: 1 forces the segments dark. The decoder output is gated with this flag externally.
- `digit_sel`, out, DIGITS: active-low one-hot digit enable; all ones means no digit is driven.
- `dp_out`, out, 1: active-low decimal point for the current digit.

## Operation
- **Buffers**
  - The pending register and `pend_valid` flag are written by `load`.
  - The display register is read by the scanner.
  - A `load` sets `pend_valid`. A second `load` before commit overwrites the pending register, and only one `load_ack` follows.
- **Prescaler**
  - `pcnt` counts 0..PRESCALE-1 and wraps.
  - `tick` = (`pcnt` == PRESCALE-1).
- **Digit index**
  - `idx` advances on `tick` and wraps from DIGITS-1 to 0.
  - A wrap to 0 is a frame boundary.
- **Commit**
  - On a frame-boundary tick with `pend_valid`=1: the display register takes the pending value, `pend_valid` clears, and `load_ack` pulses on the next cycle.
  - A commit never happens mid-frame.
- **Slot phases**
  - Guard phase: `pcnt` < GUARD. Here `digit_sel` is all ones and `blank`=1.
  - Active phase: `digit_sel` bit `idx` is 0 and all other bits are 1.
- **Active-phase outputs**
  - `val_out` = display nibble `idx`.
  - `dp_out` = ~display dp bit `idx`.
- **Leading-zero blanking** (BLANK_LZ=1)
  - Digit i>0 is blanked if nibbles DIGITS-1..i are all zero.
  - Digit 0 is never blanked by this rule.
  - A blanked digit still gets its `digit_sel` asserted, with `blank`=1 and `dp_out`=1.
- **Simultaneous load and commit**
  - A `load` on the same edge as a commit does not join that commit. The commit uses the pre-edge pending value.
  - The new value lands in pending, `pend_valid` stays 1, and it commits at the next frame boundary.

## Timing
- **Reset values** (`reset_n`=0 at an edge)
  - Internal state: `pcnt`=0, `idx`=0, display register=0, display dp=0, pending=0, `pend_valid`=0.
  - Outputs: `load_ack`=0, `val_out`=0, `blank`=1, `digit_sel`=all ones, `dp_out`=1.
- **Output registering**
  - All outputs are registered and reflect the post-edge `pcnt`/`idx`/display state on the same edge; there is no extra pipeline cycle.
- **Slot timing**
  - `pcnt` resets to 0 at every slot start, so each slot begins with exactly GUARD cycles of guard, then PRESCALE-GUARD active cycles.
  - Frame period = DIGITS*PRESCALE cycles.
- **Load-to-display latency**
  - Minimum is 1 cycle, when `load` is on the edge before a frame-boundary tick edge.
  - Maximum is DIGITS*PRESCALE cycles.
  - The new digit 0 first appears after the GUARD cycles of slot 0.
- **`load_ack`** is exactly one cycle, in the cycle following the commit edge.
- **Reset mid-operation**
  - Reset returns all state to reset values on the next edge.
  - A pending but uncommitted value is discarded, and no `load_ack` is issued.
- **Scanning** starts on the first edge after `reset_n` rises. Slot 0 begins with guard, and the display shows 0 (digit 0 only when BLANK_LZ=1).

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, GUARD=2.
- **Reset:** hold `reset_n`=0 for 3 cycles, then release.
  - Outputs show `digit_sel`=4'b1111, `blank`=1, `dp_out`=1, `val_out`=0, `load_ack`=0.
  - Then `digit_sel`=4'b1110 with `blank`=0 on cycles 2..7 of slot 0 only.
  - Digits 1..3 are blanked (LZ) in every frame.
- **Basic scan:** `load` with `value_in`=16'h12AF, `dp_in`=4'b0100.
  - After the next frame boundary, `load_ack` is a single pulse.
  - Active phases show `val_out` F, A, 2, 1 with `digit_sel` 1110, 1101, 1011, 0111.
  - `dp_out`=0 only in slot 2. Each slot has 2 guard cycles with `digit_sel`=1111.
- **Leading-zero blanking:**
  - `value_in`=16'h0030: slots 2 and 3 have `blank`=1; slot 1 shows 3; slot 0 shows 0 unblanked.
  - Rerun with BLANK_LZ=0: all four digits are unblanked.
- **No tearing / last wins:**
  - While 16'h1111 is displayed, `load` 16'h2222 in slot 1, then 16'h3333 in slot 2.
  - Slot 3 still shows 1. The next frame shows 3333 in all slots, with exactly one `load_ack`.
- **Simultaneous load and commit:**
  - Pending holds 16'hAAAA. On the frame-boundary tick edge, `load` 16'h5555.
  - The frame shows AAAA, `load_ack` pulses, and `pend_valid` stays 1.
  - The next frame shows 5555, with a second `load_ack`.
- **Reset mid-operation:**
  - `load` 16'hBEEF, then assert `reset_n`=0 for 1 cycle in slot 2, before the frame boundary.
  - After release there is no `load_ack`, and the display shows 0 (LZ) through at least 2 full frames.
